// File: rtl/stage_sequencer_if.sv
// Signal bundle between the front panel / cycle_control side and stage_sequencer.
// state_dbg exposes the sequencer FSM state for checkers and debug.
interface stage_sequencer_if;
  logic       start_btn;
  logic       pause_btn;
  logic       cancel_btn;
  logic       skip_prewash;
  logic       door_closed;
  logic       next;
  logic [3:0] stage_bus;
  logic       running;
  logic       paused;
  logic       done;
  logic       door_lock;
  logic       buzzer;
  logic [1:0] state_dbg;

  // master drives the requests and observes the results; slave is the sequencer.
  modport master (
    output start_btn, pause_btn, cancel_btn, skip_prewash, door_closed, next,
    input  stage_bus, running, paused, done, door_lock, buzzer, state_dbg
  );
  modport slave (
    input  start_btn, pause_btn, cancel_btn, skip_prewash, door_closed, next,
    output stage_bus, running, paused, done, door_lock, buzzer, state_dbg
  );
endinterface

// File: rtl/stage_sequencer.sv
// Wash-cycle stage sequencer: owns run/pause/done state and the stage code
// handed to cycle_control, advancing one stage per rising edge of next.
module stage_sequencer #(
  parameter int LAST_STAGE    = 12,
  parameter int SKIP_TO_STAGE = 3,
  parameter int DRAIN_STAGE   = 10,
  parameter int BUZZ_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  stage_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [3:0]  LAST_C  = 4'(LAST_STAGE);
  localparam logic [3:0]  SKIP_C  = 4'(SKIP_TO_STAGE);
  localparam logic [3:0]  DRAIN_C = 4'(DRAIN_STAGE);
  localparam logic [15:0] BUZZ_LOAD = 16'(BUZZ_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_stage;
  logic [15:0] r_buzz_cnt;
  logic        r_start_q, r_pause_q, r_cancel_q, r_next_q, r_door_q;
  logic        r_running, r_paused, r_done, r_door_lock, r_buzzer;

  state_t      w_state_nxt;
  logic [3:0]  w_stage_nxt;
  logic [15:0] w_buzz_cnt_nxt;
  logic        w_running_nxt, w_paused_nxt, w_done_nxt, w_door_lock_nxt, w_buzzer_nxt;
  logic        w_start_ev, w_pause_ev, w_cancel_ev, w_next_ev, w_door_fall, w_cancel_hit;

  assign w_start_ev   = bus.start_btn  & ~r_start_q;
  assign w_pause_ev   = bus.pause_btn  & ~r_pause_q;
  assign w_cancel_ev  = bus.cancel_btn & ~r_cancel_q;
  assign w_next_ev    = bus.next       & ~r_next_q;
  assign w_door_fall  = r_door_q & ~bus.door_closed;
  // A cancel past the drain point is not an event at all, so it does not mask lower priorities.
  assign w_cancel_hit = w_cancel_ev & (r_stage < DRAIN_C);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_stage     <= 4'd0;
      r_buzz_cnt  <= 16'd0;
      r_start_q   <= 1'b1;
      r_pause_q   <= 1'b1;
      r_cancel_q  <= 1'b1;
      r_next_q    <= 1'b1;
      r_door_q    <= 1'b0;
      r_running   <= 1'b0;
      r_paused    <= 1'b0;
      r_done      <= 1'b0;
      r_door_lock <= 1'b0;
      r_buzzer    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stage     <= w_stage_nxt;
      r_buzz_cnt  <= w_buzz_cnt_nxt;
      r_start_q   <= bus.start_btn;
      r_pause_q   <= bus.pause_btn;
      r_cancel_q  <= bus.cancel_btn;
      r_next_q    <= bus.next;
      r_door_q    <= bus.door_closed;
      r_running   <= w_running_nxt;
      r_paused    <= w_paused_nxt;
      r_done      <= w_done_nxt;
      r_door_lock <= w_door_lock_nxt;
      r_buzzer    <= w_buzzer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    case (r_state)
      S_IDLE: begin
        if (w_start_ev && bus.door_closed) begin
          w_state_nxt = S_RUN;
          w_stage_nxt = bus.skip_prewash ? SKIP_C : 4'd1;
        end
      end
      S_RUN: begin
        if (w_cancel_hit) begin
          w_stage_nxt = DRAIN_C;
        end else if (!bus.door_closed || w_pause_ev) begin
          w_state_nxt = S_PAUSE;
        end else if (w_next_ev) begin
          w_stage_nxt = 4'(r_stage + 4'd1);
          if (w_stage_nxt == LAST_C) w_state_nxt = S_DONE;
        end
      end
      S_PAUSE: begin
        if (w_cancel_hit) begin
          w_stage_nxt = DRAIN_C;
        end else if (w_pause_ev && bus.door_closed) begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (w_start_ev || w_door_fall) begin
          w_state_nxt = S_IDLE;
          w_stage_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_stage_nxt = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state after the edge.
  always_comb begin
    w_running_nxt   = (w_state_nxt == S_RUN);
    w_paused_nxt    = (w_state_nxt == S_PAUSE);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_door_lock_nxt = (w_state_nxt == S_RUN);
    w_buzz_cnt_nxt  = 16'd0;
    w_buzzer_nxt    = 1'b0;
    if (w_state_nxt == S_DONE) begin
      if (r_state != S_DONE) begin
        w_buzz_cnt_nxt = BUZZ_LOAD;
        w_buzzer_nxt   = 1'b1;
      end else if (r_buzz_cnt != 16'd0) begin
        w_buzz_cnt_nxt = r_buzz_cnt - 16'd1;
        w_buzzer_nxt   = 1'b1;
      end
    end
  end

  assign bus.stage_bus = r_stage;
  assign bus.running   = r_running;
  assign bus.paused    = r_paused;
  assign bus.done      = r_done;
  assign bus.door_lock = r_door_lock;
  assign bus.buzzer    = r_buzzer;
  assign bus.state_dbg = r_state;

endmodule
